// File: rtl/retta_ctrl_pkg.sv
// Shared types and constants for the point-on-line batch run controller.
package retta_ctrl_pkg;

    localparam int         RUNS_W      = 4;
    localparam logic [7:0] RES_TIMEOUT = 8'hFF;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        WAIT = 3'd2,
        OUT  = 3'd3,
        DONE = 3'd4
    } state_t;

    // A run count of zero encodes the maximum batch of 2**RUNS_W runs.
    function automatic logic [RUNS_W:0] decode_runs(input logic [RUNS_W-1:0] runs);
        return (runs == '0) ? {1'b1, {RUNS_W{1'b0}}} : {1'b0, runs};
    endfunction

endpackage

// File: rtl/retta_watchdog.sv
// Per-run watchdog: counts enabled cycles and flags expiry when the count equals TIMEOUT.
module retta_watchdog #(
    parameter int TIMEOUT = 127
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] count;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable && count != LIMIT) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/retta_run_ctrl.sv
// Batch scheduler: triggers the counting engine once per run, streams each count out
// over valid/ready, keeps a saturating batch total and aborts the batch on a hung run.
module retta_run_ctrl
    import retta_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 127,
    parameter int SUM_W   = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [RUNS_W-1:0] cmd_runs,
    output logic              cmd_ready,
    output logic              eng_start,
    input  logic              eng_done,
    input  logic [7:0]        eng_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [7:0]        res_data,
    output logic [RUNS_W-1:0] res_idx,
    output logic              batch_done,
    output logic [SUM_W-1:0]  batch_sum,
    output logic              timeout_err
);

    localparam logic [RUNS_W:0] ONE_RUN = (RUNS_W+1)'(1);

    state_t          state;
    state_t          state_next;
    logic [RUNS_W:0] remaining;
    logic            wd_expired;
    logic            take_result;
    logic            take_timeout;
    logic            handshake;
    logic [SUM_W:0]  sum_wide;

    retta_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (state == ARM),
        .enable  (state == WAIT),
        .expired (wd_expired)
    );

    // Done has priority over a watchdog expiry in the same cycle.
    assign take_result  = (state == WAIT) && eng_done;
    assign take_timeout = (state == WAIT) && !eng_done && wd_expired;
    assign handshake    = (state == OUT) && res_ready;
    assign sum_wide     = {1'b0, batch_sum} + (SUM_W+1)'(eng_result);

    assign cmd_ready  = (state == IDLE);
    assign eng_start  = (state == ARM);
    assign res_valid  = (state == OUT);
    assign batch_done = (state == DONE);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (cmd_valid) state_next = ARM;
            ARM:  state_next = WAIT;
            WAIT: if (take_result || take_timeout) state_next = OUT;
            OUT:  if (handshake) state_next = (remaining == ONE_RUN) ? DONE : ARM;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            remaining   <= '0;
            res_data    <= 8'd0;
            res_idx     <= '0;
            batch_sum   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && cmd_valid) begin
                remaining   <= decode_runs(cmd_runs);
                res_idx     <= '0;
                batch_sum   <= '0;
                timeout_err <= 1'b0;
            end
            if (take_result) begin
                res_data  <= eng_result;
                batch_sum <= sum_wide[SUM_W] ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];
            end else if (take_timeout) begin
                // Forcing one remaining run ends the batch after the error result.
                res_data    <= RES_TIMEOUT;
                timeout_err <= 1'b1;
                remaining   <= ONE_RUN;
            end
            if (handshake) begin
                remaining <= remaining - ONE_RUN;
                if (remaining != ONE_RUN) res_idx <= res_idx + 1'b1;
            end
        end
    end

endmodule
